// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states
// and the iteration counter width helper.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLTU = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLL  = 4'd4,
      OP_OR   = 4'd5,
      OP_AND  = 4'd6,
      OP_XOR  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_MUL  = 4'd10,
      OP_DIVU = 4'd11,
      OP_REMU = 4'd12
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Bits needed to count the WIDTH iterations of the mul/div engine.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU; the control unit is the
// master, the ALU is the slave.
interface alu_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
);
   logic               in_valid;
   logic               in_ready;
   logic               ALUSrcA;
   logic               ALUSrcB;
   logic [SHAMT_W-1:0] sa;
   logic [3:0]         ALUOp;
   logic [WIDTH-1:0]   ReadData1;
   logic [WIDTH-1:0]   ReadData2;
   logic [WIDTH-1:0]   ImExt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   result;
   logic               zero;
   logic               sign;
   logic               carry;
   logic               ovf;
   logic               illegal;

   modport master (
      output in_valid, ALUSrcA, ALUSrcB, sa, ALUOp, ReadData1, ReadData2, ImExt, out_ready,
      input  in_ready, out_valid, result, zero, sign, carry, ovf, illegal
   );

   modport slave (
      input  in_valid, ALUSrcA, ALUSrcB, sa, ALUOp, ReadData1, ReadData2, ImExt, out_ready,
      output in_ready, out_valid, result, zero, sign, carry, ovf, illegal
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative engine shared by MUL (shift-add) and DIVU/REMU (restoring divide);
// one bit per cycle for WIDTH cycles after start.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             start,
   input  logic             is_mul,
   input  logic             want_rem,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] result
);
   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] shf_q, shf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             mul_q, mul_d;
   logic             rem_q, rem_d;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         acc_q  <= '0;
         opnd_q <= '0;
         shf_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         mul_q  <= 1'b0;
         rem_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         shf_q  <= shf_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         mul_q  <= mul_d;
         rem_q  <= rem_d;
      end
   end

   // A zero divisor never borrows, so the quotient fills with ones and the
   // remainder ends up equal to the dividend without any special case.
   always_comb begin
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      shf_d     = shf_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      mul_d     = mul_q;
      rem_d     = rem_q;
      rem_shift = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
      trial     = rem_shift - {1'b0, opnd_q};
      if (start) begin
         acc_d  = '0;
         opnd_d = is_mul ? op_a : op_b;
         shf_d  = is_mul ? op_b : op_a;
         cnt_d  = '0;
         busy_d = 1'b1;
         mul_d  = is_mul;
         rem_d  = want_rem;
      end else if (busy_q) begin
         if (mul_q) begin
            if (shf_q[0]) begin
               acc_d = {1'b0, acc_q[WIDTH-1:0] + opnd_q};
            end
            opnd_d = opnd_q << 1;
            shf_d  = shf_q >> 1;
         end else if (!trial[WIDTH]) begin
            acc_d = trial;
            shf_d = {shf_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = rem_shift;
            shf_d = {shf_q[WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(WIDTH - 1)) begin
            busy_d = 1'b0;
         end
      end
   end

   // The final iteration's value is presented combinationally so the top
   // can register it on the same edge the engine finishes.
   assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
   assign result = (mul_q || rem_q) ? acc_d[WIDTH-1:0] : shf_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and registered flags.
// Define ALU_MULDIV_EN to build MUL/DIVU/REMU on the iterative engine.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic     CLK,
   input  logic     Reset,
   alu_seq_if.slave bus
);
`ifdef ALU_MULDIV_EN
   localparam bit MULDIV_EN = 1'b1;
`else
   localparam bit MULDIV_EN = 1'b0;
`endif

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             sign_q, sign_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0]   op_a, op_b;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     sum, diff;
   logic [WIDTH-1:0]   alu_r;
   logic               alu_c, alu_v, alu_ill;
   logic               accept, is_iter, load, eng_start, eng_done;
   logic [WIDTH-1:0]   eng_result;

   assign op_a   = bus.ALUSrcA ? {{(WIDTH - SHAMT_W){1'b0}}, bus.sa} : bus.ReadData1;
   assign op_b   = bus.ALUSrcB ? bus.ImExt : bus.ReadData2;
   assign shamt  = op_a[SHAMT_W-1:0];
   assign sum    = {1'b0, op_a} + {1'b0, op_b};
   assign diff   = {1'b0, op_a} - {1'b0, op_b};
   assign accept = bus.in_valid && (state_q == IDLE);
   assign is_iter = MULDIV_EN && ((bus.ALUOp == OP_MUL) || (bus.ALUOp == OP_DIVU) ||
                                  (bus.ALUOp == OP_REMU));

   always_comb begin
      alu_r   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (bus.ALUOp)
         OP_ADD: begin
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_r = diff[WIDTH-1:0];
            alu_c = diff[WIDTH];
            alu_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SLTU: alu_r = {{(WIDTH - 1){1'b0}}, (op_a < op_b)};
         OP_SLT:  alu_r = {{(WIDTH - 1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLL:  alu_r = op_b << shamt;
         OP_OR:   alu_r = op_a | op_b;
         OP_AND:  alu_r = op_a & op_b;
         OP_XOR:  alu_r = op_a ^ op_b;
         OP_SRL:  alu_r = op_b >> shamt;
         OP_SRA:  alu_r = $unsigned($signed(op_b) >>> shamt);
         OP_MUL, OP_DIVU, OP_REMU: alu_ill = !MULDIV_EN;
         default: alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         result_q  <= '0;
         zero_q    <= 1'b0;
         sign_q    <= 1'b0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         sign_q    <= sign_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
      end
   end

   // zero/sign only move when a new result is loaded, so they keep their
   // reset value of 0 until the first operation completes.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      sign_d    = sign_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;
      eng_start = 1'b0;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_iter) begin
                  eng_start = 1'b1;
                  state_d   = ITER;
               end else begin
                  state_d   = DONE;
                  load      = 1'b1;
                  result_d  = alu_r;
                  carry_d   = alu_c;
                  ovf_d     = alu_v;
                  illegal_d = alu_ill;
               end
            end
         end
         ITER: begin
            if (eng_done) begin
               state_d   = DONE;
               load      = 1'b1;
               result_d  = eng_result;
               carry_d   = 1'b0;
               ovf_d     = 1'b0;
               illegal_d = 1'b0;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         zero_d = (result_d == '0);
         sign_d = result_d[WIDTH-1];
      end
   end

`ifdef ALU_MULDIV_EN
   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .CLK      (CLK),
      .Reset    (Reset),
      .start    (eng_start),
      .is_mul   (bus.ALUOp == OP_MUL),
      .want_rem (bus.ALUOp == OP_REMU),
      .op_a     (op_a),
      .op_b     (op_b),
      .done     (eng_done),
      .result   (eng_result)
   );
`else
   assign eng_done   = 1'b0;
   assign eng_result = '0;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.sign      = sign_q;
   assign bus.carry     = carry_q;
   assign bus.ovf       = ovf_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=32) against a behavioural
// reference model; follows ALU_MULDIV_EN the same way the design does.
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   test_count = 0;
   int   fail_count = 0;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit isMulDiv(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
      return (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
`else
      return 1'b0;
`endif
   endfunction

   // Reference behaviour from plain integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic c, output logic v,
                                 output logic il);
      longint s;
      logic [63:0] p;
      r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
      case (op)
         4'd0: begin
            p = {32'd0, a} + {32'd0, b};
            r = p[31:0];
            c = p[32];
            s = longint'($signed(a)) + longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2: r = (a < b) ? 32'd1 : 32'd0;
         4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4: r = b << a[4:0];
         4'd5: r = a | b;
         4'd6: r = a & b;
         4'd7: r = a ^ b;
         4'd8: r = b >> a[4:0];
         4'd9: r = $unsigned($signed(b) >>> a[4:0]);
`ifdef ALU_MULDIV_EN
         4'd10: begin
            p = {32'd0, a} * {32'd0, b};
            r = p[31:0];
         end
         4'd11: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         4'd12: r = (b == 32'd0) ? a : a % b;
`endif
         default: il = 1'b1;
      endcase
   endfunction

   task automatic applyStimulus(input string name, input logic [3:0] op, input logic src_a,
                                input logic src_b, input logic [4:0] sa, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm, input int hold);
      logic [31:0] a, b, exp_r;
      logic exp_c, exp_v, exp_il;
      int exp_lat, lat, waited;
      a = src_a ? {27'd0, sa} : rd1;
      b = src_b ? imm : rd2;
      model(op, a, b, exp_r, exp_c, exp_v, exp_il);
      exp_lat = isMulDiv(op) ? 33 : 1;

      @(negedge clk);
      waited = 0;
      while (!bus.in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) checkOutput({name, " in_ready timeout"}, 32'(bus.in_ready), 32'd1);
      bus.ALUOp = op; bus.ALUSrcA = src_a; bus.ALUSrcB = src_b; bus.sa = sa;
      bus.ReadData1 = rd1; bus.ReadData2 = rd2; bus.ImExt = imm; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.ReadData1 = $urandom; bus.ReadData2 = $urandom; bus.ImExt = $urandom;
      bus.sa = 5'($urandom); bus.ALUOp = 4'($urandom);

      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, " result"}, bus.result, exp_r);
      checkOutput({name, " zero"}, 32'(bus.zero), 32'(exp_r == 32'd0));
      checkOutput({name, " sign"}, 32'(bus.sign), 32'(exp_r[31]));
      checkOutput({name, " carry"}, 32'(bus.carry), 32'(exp_c));
      checkOutput({name, " ovf"}, 32'(bus.ovf), 32'(exp_v));
      checkOutput({name, " illegal"}, 32'(bus.illegal), 32'(exp_il));
      checkOutput({name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);

      bus.ALUOp = 4'd0; bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0;
      bus.ReadData1 = 32'h1234_5678; bus.ReadData2 = 32'h1111_1111;
      bus.in_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         checkOutput({name, " hold result"}, bus.result, exp_r);
         checkOutput({name, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
         checkOutput({name, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({name, " consumed out_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({name, " consumed in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   function automatic logic [31:0] pickOperand();
      logic [31:0] corners [6];
      corners = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
      if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0;
      bus.sa = '0; bus.ALUOp = '0; bus.ReadData1 = '0; bus.ReadData2 = '0; bus.ImExt = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset result", bus.result, 32'd0);
      checkOutput("reset zero", 32'(bus.zero), 32'd0);
      checkOutput("reset sign", 32'(bus.sign), 32'd0);
      checkOutput("reset carry", 32'(bus.carry), 32'd0);
      checkOutput("reset ovf", 32'(bus.ovf), 32'd0);
      checkOutput("reset illegal", 32'(bus.illegal), 32'd0);

      applyStimulus("add ovf", 4'd0, 1'b0, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 0);
      applyStimulus("add carry", 4'd0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd2, 0);
      applyStimulus("sub 5-5", 4'd1, 1'b0, 1'b0, 5'd0, 32'd5, 32'd5, 32'd0, 0);
      applyStimulus("sub 3-5", 4'd1, 1'b0, 1'b0, 5'd0, 32'd3, 32'd5, 32'd0, 0);
      applyStimulus("sub ovf", 4'd1, 1'b0, 1'b1, 5'd0, 32'h8000_0000, 32'd0, 32'd1, 0);
      applyStimulus("slt", 4'd3, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
      applyStimulus("sltu", 4'd2, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
      applyStimulus("sra sa", 4'd9, 1'b1, 1'b0, 5'd4, 32'd0, 32'h8000_0000, 32'd0, 0);
      applyStimulus("sll upper", 4'd4, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFE3, 32'h0000_00F1, 32'd0, 0);
      applyStimulus("srl", 4'd8, 1'b1, 1'b0, 5'd31, 32'd0, 32'h8000_0000, 32'd0, 0);
      applyStimulus("mul", 4'd10, 1'b0, 1'b0, 5'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 0);
      applyStimulus("divu", 4'd11, 1'b0, 1'b1, 5'd0, 32'd100, 32'd0, 32'd7, 0);
      applyStimulus("divu by 0", 4'd11, 1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
      applyStimulus("remu by 0", 4'd12, 1'b0, 1'b0, 5'd0, 32'd9, 32'd0, 32'd0, 0);
      applyStimulus("illegal op", 4'd14, 1'b0, 1'b0, 5'd0, 32'd1, 32'd2, 32'd0, 0);
      applyStimulus("hold xor", 4'd7, 1'b0, 1'b0, 5'd0, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'd0, 5);

      for (int i = 0; i < 60; i++) begin
         applyStimulus($sformatf("rand%0d", i), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                       5'($urandom), pickOperand(), pickOperand(), pickOperand(),
                       int'($urandom_range(0, 2)));
      end

      // Reset while an operation is in flight (ITER with mul/div, DONE otherwise).
      @(negedge clk);
      bus.ALUOp = isMulDiv(4'd10) ? 4'd10 : 4'd0;
      bus.ALUSrcA = 1'b0; bus.ALUSrcB = 1'b0;
      bus.ReadData1 = 32'd3; bus.ReadData2 = 32'd4; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midop reset out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("midop reset in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("midop reset result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("after reset", 4'd5, 1'b0, 1'b0, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
